seq_mem_wr_module: RTL and testbench

Sequential memory writer: the write-side counterpart of the sequential memory read template. It accepts a write command (base address, capacity), consumes a stream of `{data, last}` beats from the previous module, and writes each beat to consecutive addresses `base_addr + n*addr_inc`. Once the stream ends or capacity is reached, it reports the number of entries written and an overflow flag to the next module. It sits at the tail of a streaming pipeline, between the final compute stage and the memory port.

---
 rtl/seq_mem_wr_module.sv | 116 +++++++++++
 tb/tb_seq_mem_wr_module.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mem_wr_module.sv
// Sequential memory writer: takes a (base, capacity) command and writes stream beats
// to consecutive addresses, then reports {overflow, count} to the next stage.
module seq_mem_wr_module #(
    parameter int addr_width   = 64,
    parameter int cntr_width   = 64,
    parameter int data_width   = 64,
    parameter int input_width  = data_width + 1,
    parameter int output_width = cntr_width + 1,
    parameter int addr_inc     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [addr_width-1:0]   base_addr,
    input  logic [cntr_width-1:0]   queue_length,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [input_width-1:0]  data_i,
    output logic                    mem_write,
    output logic [addr_width-1:0]   mem_addr,
    output logic [data_width-1:0]   mem_wdata,
    input  logic                    mem_resp,
    output logic                    valid_o,
    output logic [output_width-1:0] data_o,
    input  logic                    ready_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [cntr_width-1:0] C_ONE = cntr_width'(1);
    localparam logic [cntr_width-1:0] C_INC = cntr_width'(addr_inc);

    state_t                  r_state;
    logic [addr_width-1:0]   r_base;
    logic [cntr_width-1:0]   r_len;
    logic [cntr_width-1:0]   r_cntr;
    logic                    r_overflow;
    logic [data_width-1:0]   r_wbuf;
    logic                    r_last;

    logic [cntr_width-1:0]   w_cntr_nxt;
    logic [addr_width-1:0]   w_offset;
    logic [addr_width-1:0]   w_addr;

    assign w_cntr_nxt = r_cntr + C_ONE;
    assign w_offset   = addr_width'(r_cntr * C_INC);
    assign w_addr     = r_base + w_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_cntr     <= '0;
            r_overflow <= 1'b0;
            r_wbuf     <= '0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_base     <= base_addr;
                        r_len      <= queue_length;
                        r_cntr     <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= (queue_length == '0) ? S_DONE : S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (valid_i) begin
                        r_wbuf  <= data_i[input_width-1:1];
                        r_last  <= data_i[0];
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // last takes precedence, so a beat that exactly fills capacity is not an overflow
                    if (mem_resp) begin
                        r_cntr <= w_cntr_nxt;
                        if (r_last) begin
                            r_overflow <= 1'b0;
                            r_state    <= S_DONE;
                        end else if (w_cntr_nxt == r_len) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state, so no input reaches an output combinationally
    assign cmd_ready_o = (r_state == S_IDLE);
    assign ready_o     = (r_state == S_ACCEPT);
    assign mem_write   = (r_state == S_WRITE);
    assign mem_addr    = (r_state == S_WRITE) ? w_addr : '0;
    assign mem_wdata   = (r_state == S_WRITE) ? r_wbuf : '0;
    assign valid_o     = (r_state == S_DONE);
    assign data_o      = (r_state == S_DONE) ? {r_overflow, r_cntr} : '0;

endmodule

// File: tb/tb_seq_mem_wr_module.sv
// Directed bench for seq_mem_wr_module: a vector table for the basic flows plus
// hand-written stall, reset and completion-backpressure sequences.
module tb_seq_mem_wr_module;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [63:0]   base_addr;
    logic [63:0]   queue_length;
    logic          valid_i;
    logic          ready_o;
    logic [64:0]   data_i;
    logic          mem_write;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_resp;
    logic          valid_o;
    logic [64:0]   data_o;
    logic          ready_i;

    int checks = 0;
    int errors = 0;

    seq_mem_wr_module dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .base_addr    (base_addr),
        .queue_length (queue_length),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [63:0] base;
        logic [63:0] len;
        logic        v;
        logic [63:0] d;
        logic        last;
        logic        resp;
        logic        rdy;
        logic        e_cr;
        logic        e_ro;
        logic        e_mw;
        logic [63:0] e_ma;
        logic [63:0] e_md;
        logic        e_vo;
        logic        e_ovf;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, cv, input logic [63:0] b, l, input logic v,
                       input logic [63:0] d, input logic lst, rsp, rdy,
                       input logic cr, ro, mw, input logic [63:0] ma, md,
                       input logic vo, ovf, input logic [63:0] cnt);
        vec_t t;
        t.rst = r; t.cv = cv; t.base = b; t.len = l; t.v = v; t.d = d;
        t.last = lst; t.resp = rsp; t.rdy = rdy;
        t.e_cr = cr; t.e_ro = ro; t.e_mw = mw; t.e_ma = ma; t.e_md = md;
        t.e_vo = vo; t.e_ovf = ovf; t.e_cnt = cnt;
        vq.push_back(t);
    endtask

    task automatic drv(input logic r, cv, input logic [63:0] b, l, input logic v,
                       input logic [63:0] d, input logic lst, rsp, rdy);
        rst          = r;
        cmd_valid_i  = cv;
        base_addr    = b;
        queue_length = l;
        valid_i      = v;
        data_i       = {d, lst};
        mem_resp     = rsp;
        ready_i      = rdy;
    endtask

    task automatic chk(input string nm, input logic [64:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic exp_out(input string nm, input logic cr, ro, mw,
                           input logic [63:0] ma, md, input logic vo, ovf,
                           input logic [63:0] cnt);
        chk({nm, "_cmd_ready"}, 65'(cmd_ready_o), 65'(cr));
        chk({nm, "_ready_o"},   65'(ready_o),     65'(ro));
        chk({nm, "_mem_write"}, 65'(mem_write),   65'(mw));
        chk({nm, "_mem_addr"},  65'(mem_addr),    65'(ma));
        chk({nm, "_mem_wdata"}, 65'(mem_wdata),   65'(md));
        chk({nm, "_valid_o"},   65'(valid_o),     65'(vo));
        chk({nm, "_data_o"},    data_o,           {ovf, cnt});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        exp_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);

        // rst cv base len v d last resp rdy | cr ro mw addr wdata vo ovf cnt
        add(0, 1, 64'h1000, 4, 0, 0,     0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 1, 64'hA, 0, 0, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h1000, 64'hA, 0, 0, 0);
        add(0, 0, 0,        0, 1, 64'hB, 0, 0, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h1004, 64'hB, 0, 0, 0);
        add(0, 0, 0,        0, 1, 64'hC, 1, 0, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h1008, 64'hC, 0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 0, 1,  0, 0, 0, 0,        0,     1, 0, 3);
        // capacity overflow; mem_resp in ACCEPT must be ignored
        add(0, 1, 64'h3000, 2, 0, 0,     0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 1, 64'h1, 0, 1, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h3000, 64'h1, 0, 0, 0);
        add(0, 0, 0,        0, 1, 64'h2, 0, 0, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h3004, 64'h2, 0, 0, 0);
        add(0, 0, 0,        0, 1, 64'h3, 0, 0, 0,  0, 0, 0, 0,        0,     1, 1, 2);
        add(0, 0, 0,        0, 1, 64'h3, 0, 0, 1,  0, 0, 0, 0,        0,     1, 1, 2);
        add(0, 0, 0,        0, 1, 64'h3, 0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);
        // zero length
        add(0, 1, 64'h5000, 0, 0, 0,     0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 0, 1,  0, 0, 0, 0,        0,     1, 0, 0);
        // last on the beat that exactly fills capacity
        add(0, 1, 64'h10,   1, 0, 0,     0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 1, 64'h7, 1, 0, 0,  0, 1, 0, 0,        0,     0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 1, 0,  0, 0, 1, 64'h10,   64'h7, 0, 0, 0);
        add(0, 0, 0,        0, 0, 0,     0, 0, 1,  0, 0, 0, 0,        0,     1, 0, 1);
        add(0, 0, 0,        0, 0, 0,     0, 0, 0,  1, 0, 0, 0,        0,     0, 0, 0);

        foreach (vq[i]) begin
            exp_out($sformatf("vec%0d", i), vq[i].e_cr, vq[i].e_ro, vq[i].e_mw, vq[i].e_ma,
                    vq[i].e_md, vq[i].e_vo, vq[i].e_ovf, vq[i].e_cnt);
            drv(vq[i].rst, vq[i].cv, vq[i].base, vq[i].len, vq[i].v, vq[i].d,
                vq[i].last, vq[i].resp, vq[i].rdy);
            step();
        end

        // memory stall: 5 cycles without mem_resp, then a single completion
        drv(0, 1, 64'h4000, 3, 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 64'h55, 0, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            exp_out($sformatf("stall%0d", i), 0, 0, 1, 64'h4000, 64'h55, 0, 0, 0);
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        exp_out("stall_resp", 0, 0, 1, 64'h4000, 64'h55, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        exp_out("stall_acc", 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 64'h66, 1, 0, 0);
        step();
        exp_out("stall_wr2", 0, 0, 1, 64'h4004, 64'h66, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        exp_out("stall_done", 0, 0, 0, 0, 0, 1, 0, 2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // reset during the write of entry 1
        drv(0, 1, 64'h6000, 4, 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 64'h11, 0, 0, 0);
        step();
        exp_out("rst_wr0", 0, 0, 1, 64'h6000, 64'h11, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        drv(0, 0, 0, 0, 1, 64'h22, 0, 0, 0);
        step();
        exp_out("rst_wr1", 0, 0, 1, 64'h6004, 64'h22, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        exp_out("rst_after", 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 64'h2000, 1, 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 64'h99, 1, 0, 0);
        step();
        exp_out("rst_new_wr", 0, 0, 1, 64'h2000, 64'h99, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        exp_out("rst_new_done", 0, 0, 0, 0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // completion backpressure with a pending command
        drv(0, 1, 64'h0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            exp_out($sformatf("bp_hold%0d", i), 0, 0, 0, 0, 0, 1, 0, 0);
            drv(0, 1, 64'h7000, 1, 0, 0, 0, 0, 0);
            step();
        end
        exp_out("bp_rdy", 0, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 1, 64'h7000, 1, 0, 0, 0, 0, 1);
        step();
        exp_out("bp_idle", 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 64'h7000, 1, 0, 0, 0, 0, 0);
        step();
        exp_out("bp_acc", 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 64'h77, 1, 0, 0);
        step();
        exp_out("bp_wr", 0, 0, 1, 64'h7000, 64'h77, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        exp_out("bp_done", 0, 0, 0, 0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        exp_out("bp_end", 1, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
